clock_gate_controller: RTL and testbench

//   Power-management scheduler for N_CH clock-gated register banks.

---
 rtl/clock_gate_controller_if.sv | 11 +
 rtl/clock_gate_controller.sv | 94 +++++++++
 tb/tb_clock_gate_controller.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/clock_gate_controller_if.sv
// clock_gate_controller_if: request/bypass inputs and gating outputs of the clock gate controller
interface clock_gate_controller_if #(parameter int N_CH = 4);
   logic [N_CH-1:0]           req;
   logic                      bypass;
   logic [N_CH-1:0]           gate_en;
   logic [N_CH-1:0]           ready;
   logic [N_CH-1:0]           wake_gnt;
   logic [$clog2(N_CH+1)-1:0] gated_cnt;
   modport master (output req, bypass, input gate_en, ready, wake_gnt, gated_cnt);
   modport slave  (input req, bypass, output gate_en, ready, wake_gnt, gated_cnt);
endinterface

// File: rtl/clock_gate_controller.sv
// clock_gate_controller: per-bank idle gating with round-robin, one-per-cycle wake scheduling
module clock_gate_controller #(
   parameter int N_CH        = 4,
   parameter int IDLE_CYCLES = 8,
   parameter int WAKE_CYCLES = 2,
   parameter int CNT_W       = 4
) (
   input logic                     clk,
   input logic                     rst,
   clock_gate_controller_if.slave  bus
);
   localparam int PW = $clog2(N_CH);
   localparam int GW = $clog2(N_CH+1);
   typedef enum logic [1:0] {OFF, WAKE, RUN, IDLE} state_t;
   state_t           r_state [N_CH];
   state_t           w_nxt [N_CH];
   logic [CNT_W-1:0] r_timer [N_CH];
   logic [CNT_W-1:0] w_tmr [N_CH];
   logic [PW-1:0]    r_ptr, w_ptr_nxt;
   logic [N_CH-1:0]  w_keep, w_cand, w_gnt;
   logic [N_CH-1:0]  r_gate_en, r_ready, r_wake_gnt;
   logic [GW-1:0]    r_gated_cnt, w_cnt;
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         w_keep[i] = bus.req[i] | bus.bypass;
         w_cand[i] = (r_state[i] == OFF) & w_keep[i];
      end
   end
   // scan from the farthest offset down so the candidate nearest the pointer wins
   always_comb begin
      int idx;
      idx = 0;
      w_gnt = '0;
      w_ptr_nxt = r_ptr;
      for (int k = N_CH - 1; k >= 0; k--) begin
         idx = (int'(r_ptr) + k) % N_CH;
         if (w_cand[idx[PW-1:0]]) begin
            w_gnt = '0;
            w_gnt[idx[PW-1:0]] = 1'b1;
            w_ptr_nxt = (idx == N_CH - 1) ? '0 : PW'(idx + 1);
         end
      end
   end
   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_nxt[i] = r_state[i];
         w_tmr[i] = r_timer[i];
         unique case (r_state[i])
            RUN:  if (!w_keep[i]) begin
                     w_nxt[i] = IDLE;
                     w_tmr[i] = CNT_W'(IDLE_CYCLES - 1);
                  end
            IDLE: if (w_keep[i]) w_nxt[i] = RUN;
                  else if (r_timer[i] == '0) w_nxt[i] = OFF;
                  else w_tmr[i] = r_timer[i] - 1'b1;
            OFF:  if (w_gnt[i]) begin
                     w_nxt[i] = WAKE;
                     w_tmr[i] = CNT_W'(WAKE_CYCLES - 1);
                  end
            WAKE: if (r_timer[i] == '0) w_nxt[i] = RUN;
                  else w_tmr[i] = r_timer[i] - 1'b1;
         endcase
         w_cnt = w_cnt + GW'(w_nxt[i] == OFF);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            r_state[i] <= OFF;
            r_timer[i] <= '0;
         end
         r_ptr       <= '0;
         r_gate_en   <= '0;
         r_ready     <= '0;
         r_wake_gnt  <= '0;
         r_gated_cnt <= GW'(N_CH);
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            r_state[i]   <= w_nxt[i];
            r_timer[i]   <= w_tmr[i];
            r_gate_en[i] <= w_nxt[i] != OFF;
            r_ready[i]   <= (w_nxt[i] == RUN) || (w_nxt[i] == IDLE);
         end
         r_ptr       <= w_ptr_nxt;
         r_wake_gnt  <= w_gnt;
         r_gated_cnt <= w_cnt;
      end
   end
   assign bus.gate_en   = r_gate_en;
   assign bus.ready     = r_ready;
   assign bus.wake_gnt  = r_wake_gnt;
   assign bus.gated_cnt = r_gated_cnt;
endmodule

// File: tb/tb_clock_gate_controller.sv
// tb_clock_gate_controller: directed stimulus with a cycle-level behavioural model and literal checkpoints
module tb_clock_gate_controller;
   localparam int N = 4;
   localparam int IDLE = 8;
   localparam int WAKE = 2;
   logic clk = 1'b0;
   logic rst;
   int total = 0;
   int bad = 0;
   clock_gate_controller_if #(.N_CH(N)) bus ();
   clock_gate_controller #(.N_CH(N), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   // model: a bank is off, waking with a countdown to ready, or on with a count of idle cycles seen
   bit m_off [N];
   int m_wl [N];
   int m_idle [N];
   int m_ptr;
   logic [N-1:0] m_gnt;
   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask
   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_off[i] = 1'b1;
         m_wl[i] = 0;
         m_idle[i] = 0;
      end
      m_ptr = 0;
      m_gnt = '0;
   endtask
   task automatic m_step();
      int g;
      int idx;
      g = -1;
      for (int k = 0; k < N; k++) begin
         idx = (m_ptr + k) % N;
         if (g < 0 && m_off[idx] && (bus.req[idx] || bus.bypass)) g = idx;
      end
      m_gnt = '0;
      for (int i = 0; i < N; i++) begin
         if (m_off[i]) begin
            if (i == g) begin
               m_off[i] = 1'b0;
               m_wl[i] = WAKE;
               m_idle[i] = 0;
               m_gnt[i] = 1'b1;
            end
         end else if (m_wl[i] > 0) m_wl[i]--;
         else if (bus.req[i] || bus.bypass) m_idle[i] = 0;
         else begin
            m_idle[i]++;
            if (m_idle[i] > IDLE) m_off[i] = 1'b1;
         end
      end
      if (g >= 0) m_ptr = (g + 1) % N;
   endtask
   function automatic logic [N-1:0] m_gate_en();
      for (int i = 0; i < N; i++) m_gate_en[i] = !m_off[i];
   endfunction
   function automatic logic [N-1:0] m_ready();
      for (int i = 0; i < N; i++) m_ready[i] = !m_off[i] && m_wl[i] == 0;
   endfunction
   function automatic int m_cnt();
      m_cnt = 0;
      for (int i = 0; i < N; i++) m_cnt += int'(m_off[i]);
   endfunction
   initial begin
      m_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) m_reset();
         else m_step();
      end
   end
   initial begin
      forever begin
         @(negedge clk);
         chk("model gate_en", 32'(bus.gate_en), 32'(m_gate_en()));
         chk("model ready", 32'(bus.ready), 32'(m_ready()));
         chk("model wake_gnt", 32'(bus.wake_gnt), 32'(m_gnt));
         chk("model gated_cnt", 32'(bus.gated_cnt), 32'(m_cnt()));
      end
   end
   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      logic [3:0] rdy_exp [6];
      rdy_exp = '{4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
      rst = 1'b1;
      bus.req = '0;
      bus.bypass = 1'b0;
      tick(2);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         chk("idle gate_en", 32'(bus.gate_en), 0);
         chk("idle gated_cnt", 32'(bus.gated_cnt), 4);
      end
      bus.req = 4'b0001;
      tick(1);
      chk("wake gnt0", 32'(bus.wake_gnt), 1);
      chk("wake gate_en0", 32'(bus.gate_en), 1);
      chk("wake ready early", 32'(bus.ready), 0);
      chk("wake cnt", 32'(bus.gated_cnt), 3);
      tick(1);
      chk("wake gnt pulse", 32'(bus.wake_gnt), 0);
      chk("wake ready mid", 32'(bus.ready), 0);
      tick(1);
      chk("wake ready0", 32'(bus.ready), 1);
      chk("wake others", 32'(bus.gate_en), 1);
      tick(3);
      bus.req = '0;
      tick(1);
      chk("idle still on", 32'(bus.gate_en), 1);
      chk("idle still ready", 32'(bus.ready), 1);
      tick(7);
      chk("idle before off", 32'(bus.gate_en), 1);
      tick(1);
      chk("idle gated", 32'(bus.gate_en), 0);
      chk("idle cnt back", 32'(bus.gated_cnt), 4);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      bus.req = 4'b1111;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         chk("rr gnt", 32'(bus.wake_gnt), k < 4 ? 32'(1) << k : 0);
         chk("rr ready", 32'(bus.ready), 32'(rdy_exp[k]));
      end
      bus.req = '0;
      tick(10);
      chk("rr all off", 32'(bus.gated_cnt), 4);
      bus.req = 4'b1010;
      tick(1);
      chk("rr gnt1", 32'(bus.wake_gnt), 4'b0010);
      tick(1);
      chk("rr gnt3", 32'(bus.wake_gnt), 4'b1000);
      tick(2);
      bus.req = 4'b1000;
      for (int c = 0; c < 8; c++) begin
         tick(1);
         chk("race hold", 32'(bus.gate_en[1]), 1);
      end
      bus.req = 4'b1010;
      for (int c = 0; c < 3; c++) begin
         tick(1);
         chk("race gate_en1", 32'(bus.gate_en[1]), 1);
         chk("race ready1", 32'(bus.ready[1]), 1);
      end
      chk("race cnt", 32'(bus.gated_cnt), 2);
      bus.req = 4'b1000;
      tick(3);
      chk("byp pre ready", 32'(bus.ready), 4'b1010);
      bus.bypass = 1'b1;
      tick(1);
      chk("byp gnt0", 32'(bus.wake_gnt), 4'b0001);
      chk("byp gate_en", 32'(bus.gate_en), 4'b1011);
      chk("byp cnt1", 32'(bus.gated_cnt), 1);
      tick(1);
      chk("byp gnt2", 32'(bus.wake_gnt), 4'b0100);
      chk("byp gate_all", 32'(bus.gate_en), 4'b1111);
      chk("byp cnt0", 32'(bus.gated_cnt), 0);
      rst = 1'b1;
      #1;
      chk("rst gate_en", 32'(bus.gate_en), 0);
      chk("rst ready", 32'(bus.ready), 0);
      chk("rst wake_gnt", 32'(bus.wake_gnt), 0);
      chk("rst cnt", 32'(bus.gated_cnt), 4);
      tick(2);
      rst = 1'b0;
      bus.req = '0;
      tick(12);
      chk("byp all ready", 32'(bus.ready), 4'b1111);
      chk("byp none gated", 32'(bus.gated_cnt), 0);
      bus.bypass = 1'b0;
      tick(15);
      chk("final gated", 32'(bus.gated_cnt), 4);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
